// File: rtl/lram_pkg.sv
// Shared types, default widths and the byte-lane merge used by the LRAM
// behavioural model.
package lram_pkg;

    typedef enum logic [1:0] {
        RDW_NORMAL        = 2'd0,
        RDW_WRITE_THROUGH = 2'd1,
        RDW_NO_CHANGE     = 2'd2
    } rdw_mode_e;

    localparam int LRAM_ADDR_W = 14;
    localparam int LRAM_DATA_W = 32;
    // Widest word the merge helper handles; callers size-cast in and slice out.
    localparam int LRAM_MAX_W  = 256;

    function automatic logic [LRAM_MAX_W-1:0] byte_merge(
        input logic [LRAM_MAX_W-1:0]   old_word,
        input logic [LRAM_MAX_W-1:0]   new_word,
        input logic [LRAM_MAX_W/8-1:0] ben
    );
        logic [LRAM_MAX_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < LRAM_MAX_W / 8; i++) begin
            if (ben[i]) begin
                merged[i*8 +: 8] = new_word[i*8 +: 8];
            end else begin
                merged[i*8 +: 8] = old_word[i*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/lram_port.sv
// One LRAM fabric port: access decode, read-during-write data select and the
// one- or two-stage do/dv pipeline with clock-enable stall and reset flush.
module lram_port
    import lram_pkg::*;
#(
    parameter int        DATA_W   = LRAM_DATA_W,
    parameter bit        OUTREG   = 1'b0,
    parameter rdw_mode_e RDW_MODE = RDW_NORMAL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              cs,
    input  logic              we,
    input  logic [DATA_W-1:0] rd_old,
    input  logic [DATA_W-1:0] rd_new,
    output logic [DATA_W-1:0] do_o,
    output logic              dv_o
);

    logic              access_s;
    logic              rd_vld_s;
    logic [DATA_W-1:0] rd_data_s;

    logic [DATA_W-1:0] s1_data_d, s1_data_q;
    logic              s1_vld_d,  s1_vld_q;
    logic [DATA_W-1:0] s2_data_d, s2_data_q;
    logic              s2_vld_d,  s2_vld_q;

    assign access_s  = ce & cs & ~rst;
    assign rd_vld_s  = access_s & (~we | (RDW_MODE != RDW_NO_CHANGE));
    // rd_new is the word as it will be stored, including any cross-port merge.
    assign rd_data_s = (we && (RDW_MODE == RDW_WRITE_THROUGH)) ? rd_new : rd_old;

    // Pipeline next state: everything holds while ce is low.
    always_comb begin
        s1_data_d = s1_data_q;
        s1_vld_d  = s1_vld_q;
        s2_data_d = s2_data_q;
        s2_vld_d  = s2_vld_q;
        if (ce) begin
            s1_vld_d  = rd_vld_s;
            s1_data_d = rd_vld_s ? rd_data_s : s1_data_q;
            s2_vld_d  = s1_vld_q;
            s2_data_d = s1_vld_q ? s1_data_q : s2_data_q;
        end else begin
            s1_vld_d  = s1_vld_q;
            s2_vld_d  = s2_vld_q;
        end
    end

    // Pipeline registers with synchronous flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data_q <= '0;
            s1_vld_q  <= 1'b0;
            s2_data_q <= '0;
            s2_vld_q  <= 1'b0;
        end else begin
            s1_data_q <= s1_data_d;
            s1_vld_q  <= s1_vld_d;
            s2_data_q <= s2_data_d;
            s2_vld_q  <= s2_vld_d;
        end
    end

    assign do_o = OUTREG ? s2_data_q : s1_data_q;
    assign dv_o = OUTREG ? s2_vld_q  : s1_vld_q;

endmodule

// File: rtl/lram_model.sv
// Cycle-accurate two-port LRAM responder: shared array, cross-port write
// arbitration (port A wins overlapping lanes) and the registered collision flag.
module lram_model
    import lram_pkg::*;
#(
    parameter int        ADDR_W     = LRAM_ADDR_W,
    parameter int        DATA_W     = LRAM_DATA_W,
    parameter bit        OUTREG_A   = 1'b0,
    parameter bit        OUTREG_B   = 1'b0,
    parameter rdw_mode_e RDW_MODE_A = RDW_NORMAL,
    parameter rdw_mode_e RDW_MODE_B = RDW_NORMAL
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce_a,
    input  logic                cs_a,
    input  logic                we_a,
    input  logic [ADDR_W-1:0]   ad_a,
    input  logic [DATA_W/8-1:0] ben_a,
    input  logic [DATA_W-1:0]   di_a,
    output logic [DATA_W-1:0]   do_a,
    output logic                dv_a,
    input  logic                ce_b,
    input  logic                cs_b,
    input  logic                we_b,
    input  logic [ADDR_W-1:0]   ad_b,
    input  logic [DATA_W/8-1:0] ben_b,
    input  logic [DATA_W-1:0]   di_b,
    output logic [DATA_W-1:0]   do_b,
    output logic                dv_b,
    output logic                coll
);

    localparam int DEPTH = 1 << ADDR_W;

    function automatic logic [DATA_W-1:0] merge_word(
        input logic [DATA_W-1:0]   old_word,
        input logic [DATA_W-1:0]   new_word,
        input logic [DATA_W/8-1:0] ben
    );
        logic [LRAM_MAX_W-1:0] wide;
        wide = byte_merge(LRAM_MAX_W'(old_word), LRAM_MAX_W'(new_word),
                          (LRAM_MAX_W/8)'(ben));
        return wide[DATA_W-1:0];
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              wr_a_s, wr_b_s, same_addr_s;
    logic [DATA_W-1:0] old_a_s, old_b_s;
    logic [DATA_W-1:0] word_a_pre_s, word_a_s;
    logic [DATA_W-1:0] word_b_pre_s, word_b_s;
    logic              coll_d, coll_q;

    assign wr_a_s      = ce_a & cs_a & we_a & ~rst;
    assign wr_b_s      = ce_b & cs_b & we_b & ~rst;
    assign same_addr_s = (ad_a == ad_b);
    assign old_a_s     = mem_q[ad_a];
    assign old_b_s     = mem_q[ad_b];

    // Apply B first, then A on top, so A owns every lane both ports enable.
    assign word_a_pre_s = (wr_b_s && same_addr_s) ? merge_word(old_a_s, di_b, ben_b) : old_a_s;
    assign word_a_s     = wr_a_s ? merge_word(word_a_pre_s, di_a, ben_a) : word_a_pre_s;
    assign word_b_pre_s = wr_b_s ? merge_word(old_b_s, di_b, ben_b) : old_b_s;
    assign word_b_s     = (wr_a_s && same_addr_s) ? merge_word(word_b_pre_s, di_a, ben_a) : word_b_pre_s;

    // Collision detect: both ports really write the same word this edge.
    always_comb begin
        coll_d = 1'b0;
        if (wr_a_s && wr_b_s && same_addr_s && (|ben_a) && (|ben_b)) begin
            coll_d = 1'b1;
        end else begin
            coll_d = 1'b0;
        end
    end

    // Array update; both ports land the same merged word on a shared address.
    always_ff @(posedge clk) begin
        if (wr_a_s) begin
            mem_q[ad_a] <= word_a_s;
        end
        if (wr_b_s) begin
            mem_q[ad_b] <= word_b_s;
        end
    end

    // Collision flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            coll_q <= 1'b0;
        end else begin
            coll_q <= coll_d;
        end
    end

    assign coll = coll_q;

    lram_port #(
        .DATA_W   (DATA_W),
        .OUTREG   (OUTREG_A),
        .RDW_MODE (RDW_MODE_A)
    ) u_port_a (
        .clk    (clk),
        .rst    (rst),
        .ce     (ce_a),
        .cs     (cs_a),
        .we     (we_a),
        .rd_old (old_a_s),
        .rd_new (word_a_s),
        .do_o   (do_a),
        .dv_o   (dv_a)
    );

    lram_port #(
        .DATA_W   (DATA_W),
        .OUTREG   (OUTREG_B),
        .RDW_MODE (RDW_MODE_B)
    ) u_port_b (
        .clk    (clk),
        .rst    (rst),
        .ce     (ce_b),
        .cs     (cs_b),
        .we     (we_b),
        .rd_old (old_b_s),
        .rd_new (word_b_s),
        .do_o   (do_b),
        .dv_o   (dv_b)
    );

endmodule

// File: tb/tb_lram_model.sv
// Directed bench: two lram_model instances with complementary configurations
// share one stimulus stream; each task checks the instance its feature targets.
module tb_lram_model;
    import lram_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_a, cs_a, we_a, ce_b, cs_b, we_b;
    logic [13:0] ad_a, ad_b;
    logic [3:0]  ben_a, ben_b;
    logic [31:0] di_a, di_b;

    logic [31:0] do_a0, do_b0, do_a1, do_b1;
    logic        dv_a0, dv_b0, dv_a1, dv_b1, coll0, coll1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // u0: A no outreg / normal, B outreg / write-through
    lram_model #(
        .ADDR_W(14), .DATA_W(32), .OUTREG_A(1'b0), .OUTREG_B(1'b1),
        .RDW_MODE_A(RDW_NORMAL), .RDW_MODE_B(RDW_WRITE_THROUGH)
    ) u0 (
        .clk(clk), .rst(rst),
        .ce_a(ce_a), .cs_a(cs_a), .we_a(we_a), .ad_a(ad_a), .ben_a(ben_a), .di_a(di_a),
        .do_a(do_a0), .dv_a(dv_a0),
        .ce_b(ce_b), .cs_b(cs_b), .we_b(we_b), .ad_b(ad_b), .ben_b(ben_b), .di_b(di_b),
        .do_b(do_b0), .dv_b(dv_b0),
        .coll(coll0)
    );

    // u1: A outreg / no-change, B no outreg / normal
    lram_model #(
        .ADDR_W(14), .DATA_W(32), .OUTREG_A(1'b1), .OUTREG_B(1'b0),
        .RDW_MODE_A(RDW_NO_CHANGE), .RDW_MODE_B(RDW_NORMAL)
    ) u1 (
        .clk(clk), .rst(rst),
        .ce_a(ce_a), .cs_a(cs_a), .we_a(we_a), .ad_a(ad_a), .ben_a(ben_a), .di_a(di_a),
        .do_a(do_a1), .dv_a(dv_a1),
        .ce_b(ce_b), .cs_b(cs_b), .we_b(we_b), .ad_b(ad_b), .ben_b(ben_b), .di_b(di_b),
        .do_b(do_b1), .dv_b(dv_b1),
        .coll(coll1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ce_a = 1'b1; cs_a = 1'b0; we_a = 1'b0; ad_a = 14'h0; ben_a = 4'h0; di_a = 32'h0;
        ce_b = 1'b1; cs_b = 1'b0; we_b = 1'b0; ad_b = 14'h0; ben_b = 4'h0; di_b = 32'h0;
    endtask

    task automatic op_a(input logic we, input logic [13:0] ad, input logic [3:0] ben, input logic [31:0] di);
        ce_a = 1'b1; cs_a = 1'b1; we_a = we; ad_a = ad; ben_a = ben; di_a = di;
    endtask

    task automatic op_b(input logic we, input logic [13:0] ad, input logic [3:0] ben, input logic [31:0] di);
        ce_b = 1'b1; cs_b = 1'b1; we_b = we; ad_b = ad; ben_b = ben; di_b = di;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        n_tests++; if (do_a0 !== 32'h0) begin n_fail++; $display("FAIL rst_do_a0 got=%h exp=%h", do_a0, 32'h0); end
        n_tests++; if (dv_a0 !== 1'b0) begin n_fail++; $display("FAIL rst_dv_a0 got=%b exp=0", dv_a0); end
        n_tests++; if (do_b0 !== 32'h0) begin n_fail++; $display("FAIL rst_do_b0 got=%h exp=%h", do_b0, 32'h0); end
        n_tests++; if (dv_b1 !== 1'b0) begin n_fail++; $display("FAIL rst_dv_b1 got=%b exp=0", dv_b1); end
        n_tests++; if (coll0 !== 1'b0) begin n_fail++; $display("FAIL rst_coll0 got=%b exp=0", coll0); end
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        op_a(1'b1, 14'h0010, 4'hF, 32'hDEADBEEF);
        tick();
        op_a(1'b0, 14'h0010, 4'h0, 32'h0);
        tick();
        n_tests++; if (do_a0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_rd_do_a0 got=%h exp=%h", do_a0, 32'hDEADBEEF); end
        n_tests++; if (dv_a0 !== 1'b1) begin n_fail++; $display("FAIL wr_rd_dv_a0 got=%b exp=1", dv_a0); end
        n_tests++; if (dv_a1 !== 1'b0) begin n_fail++; $display("FAIL wr_rd_dv_a1_early got=%b exp=0", dv_a1); end
        idle();
        tick();
        n_tests++; if (dv_a0 !== 1'b0) begin n_fail++; $display("FAIL wr_rd_dv_a0_pulse got=%b exp=0", dv_a0); end
        n_tests++; if (do_a0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_rd_do_a0_hold got=%h exp=%h", do_a0, 32'hDEADBEEF); end
        n_tests++; if (do_a1 !== 32'hDEADBEEF || dv_a1 !== 1'b1) begin n_fail++; $display("FAIL wr_rd_outreg_a1 got=%h/%b exp=%h/1", do_a1, dv_a1, 32'hDEADBEEF); end
    endtask

    task automatic test_byte_enable();
        op_b(1'b1, 14'h0020, 4'hF, 32'h11223344);
        tick();
        op_b(1'b1, 14'h0020, 4'b0101, 32'hAABBCCDD);
        tick();
        idle();
        tick();
        n_tests++; if (do_b0 !== 32'h11BB33DD || dv_b0 !== 1'b1) begin n_fail++; $display("FAIL ben_wt_b0 got=%h/%b exp=%h/1", do_b0, dv_b0, 32'h11BB33DD); end
        tick();
        op_b(1'b0, 14'h0020, 4'h0, 32'h0);
        tick();
        idle();
        n_tests++; if (dv_b0 !== 1'b0) begin n_fail++; $display("FAIL ben_dv_b0_early got=%b exp=0", dv_b0); end
        n_tests++; if (do_b1 !== 32'h11BB33DD || dv_b1 !== 1'b1) begin n_fail++; $display("FAIL ben_rd_b1 got=%h/%b exp=%h/1", do_b1, dv_b1, 32'h11BB33DD); end
        tick();
        n_tests++; if (do_b0 !== 32'h11BB33DD || dv_b0 !== 1'b1) begin n_fail++; $display("FAIL ben_rd_b0 got=%h/%b exp=%h/1", do_b0, dv_b0, 32'h11BB33DD); end
        tick();
        n_tests++; if (dv_b0 !== 1'b0) begin n_fail++; $display("FAIL ben_dv_b0_late got=%b exp=0", dv_b0); end
    endtask

    task automatic test_rdw();
        op_a(1'b1, 14'h3FFF, 4'hF, 32'h0);
        tick();
        op_a(1'b1, 14'h3FFF, 4'hF, 32'h12345678);
        tick();
        idle();
        n_tests++; if (do_a0 !== 32'h0 || dv_a0 !== 1'b1) begin n_fail++; $display("FAIL rdw_normal_a0 got=%h/%b exp=%h/1", do_a0, dv_a0, 32'h0); end
        tick();
        n_tests++; if (do_a1 !== 32'hDEADBEEF || dv_a1 !== 1'b0) begin n_fail++; $display("FAIL rdw_nochange_a1 got=%h/%b exp=%h/0", do_a1, dv_a1, 32'hDEADBEEF); end
        op_b(1'b1, 14'h3FFF, 4'hF, 32'h0);
        tick();
        op_b(1'b1, 14'h3FFF, 4'hF, 32'h12345678);
        tick();
        idle();
        n_tests++; if (do_b1 !== 32'h0 || dv_b1 !== 1'b1) begin n_fail++; $display("FAIL rdw_normal_b1 got=%h/%b exp=%h/1", do_b1, dv_b1, 32'h0); end
        tick();
        n_tests++; if (do_b0 !== 32'h12345678 || dv_b0 !== 1'b1) begin n_fail++; $display("FAIL rdw_wt_b0 got=%h/%b exp=%h/1", do_b0, dv_b0, 32'h12345678); end
        tick();
    endtask

    task automatic test_collision();
        op_a(1'b1, 14'h0005, 4'hF, 32'h12345678);
        tick();
        idle();
        tick();
        op_a(1'b1, 14'h0005, 4'hC, 32'hFFFF0000);
        op_b(1'b1, 14'h0005, 4'hF, 32'h0000FFFF);
        tick();
        idle();
        n_tests++; if (coll0 !== 1'b1) begin n_fail++; $display("FAIL coll_set got=%b exp=1", coll0); end
        n_tests++; if (do_a0 !== 32'h12345678) begin n_fail++; $display("FAIL coll_old_a0 got=%h exp=%h", do_a0, 32'h12345678); end
        n_tests++; if (do_b1 !== 32'h12345678) begin n_fail++; $display("FAIL coll_old_b1 got=%h exp=%h", do_b1, 32'h12345678); end
        tick();
        n_tests++; if (coll0 !== 1'b0) begin n_fail++; $display("FAIL coll_one_cycle got=%b exp=0", coll0); end
        n_tests++; if (do_b0 !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL coll_merge_b0 got=%h exp=%h", do_b0, 32'hFFFFFFFF); end
        op_a(1'b0, 14'h0005, 4'h0, 32'h0);
        op_b(1'b1, 14'h0005, 4'hF, 32'h0BADF00D);
        tick();
        n_tests++; if (do_a0 !== 32'hFFFFFFFF || dv_a0 !== 1'b1) begin n_fail++; $display("FAIL xrd_old_a0 got=%h/%b exp=%h/1", do_a0, dv_a0, 32'hFFFFFFFF); end
        idle();
        op_a(1'b0, 14'h0005, 4'h0, 32'h0);
        tick();
        idle();
        n_tests++; if (do_a0 !== 32'h0BADF00D) begin n_fail++; $display("FAIL xrd_new_a0 got=%h exp=%h", do_a0, 32'h0BADF00D); end
        n_tests++; if (coll0 !== 1'b0) begin n_fail++; $display("FAIL coll_single_writer got=%b exp=0", coll0); end
        tick();
        tick();
    endtask

    task automatic test_ce_stall();
        op_a(1'b0, 14'h0010, 4'h0, 32'h0);
        tick();
        idle();
        ce_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (dv_a1 !== 1'b0 || do_a1 !== 32'h0BADF00D) begin n_fail++; $display("FAIL stall_a1_%0d got=%h/%b exp=%h/0", i, do_a1, dv_a1, 32'h0BADF00D); end
        end
        n_tests++; if (dv_a0 !== 1'b1 || do_a0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL stall_hold_a0 got=%h/%b exp=%h/1", do_a0, dv_a0, 32'hDEADBEEF); end
        ce_a = 1'b1;
        tick();
        n_tests++; if (dv_a1 !== 1'b1 || do_a1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL stall_done_a1 got=%h/%b exp=%h/1", do_a1, dv_a1, 32'hDEADBEEF); end
        n_tests++; if (dv_a0 !== 1'b0) begin n_fail++; $display("FAIL stall_drain_a0 got=%b exp=0", dv_a0); end
        tick();
        n_tests++; if (dv_a1 !== 1'b0) begin n_fail++; $display("FAIL stall_pulse_a1 got=%b exp=0", dv_a1); end
    endtask

    task automatic test_reset_mid();
        op_a(1'b0, 14'h0010, 4'h0, 32'h0);
        tick();
        n_tests++; if (dv_a1 !== 1'b0) begin n_fail++; $display("FAIL rstm_pre_a1 got=%b exp=0", dv_a1); end
        rst = 1'b1;
        op_a(1'b1, 14'h0010, 4'hF, 32'h0);
        op_b(1'b1, 14'h0010, 4'hF, 32'h0);
        tick();
        rst = 1'b0;
        idle();
        n_tests++; if (do_a1 !== 32'h0 || dv_a1 !== 1'b0) begin n_fail++; $display("FAIL rstm_a1 got=%h/%b exp=0/0", do_a1, dv_a1); end
        n_tests++; if (do_a0 !== 32'h0 || dv_a0 !== 1'b0) begin n_fail++; $display("FAIL rstm_a0 got=%h/%b exp=0/0", do_a0, dv_a0); end
        n_tests++; if (coll1 !== 1'b0) begin n_fail++; $display("FAIL rstm_coll1 got=%b exp=0", coll1); end
        tick();
        n_tests++; if (dv_a1 !== 1'b0 || coll0 !== 1'b0) begin n_fail++; $display("FAIL rstm_flush got=%b/%b exp=0/0", dv_a1, coll0); end
        op_a(1'b0, 14'h0010, 4'h0, 32'h0);
        tick();
        idle();
        n_tests++; if (do_a0 !== 32'hDEADBEEF || dv_a0 !== 1'b1) begin n_fail++; $display("FAIL rstm_kept_a0 got=%h/%b exp=%h/1", do_a0, dv_a0, 32'hDEADBEEF); end
        tick();
        n_tests++; if (do_a1 !== 32'hDEADBEEF || dv_a1 !== 1'b1) begin n_fail++; $display("FAIL rstm_kept_a1 got=%h/%b exp=%h/1", do_a1, dv_a1, 32'hDEADBEEF); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
        test_rdw();
        test_collision();
        test_ce_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
